freq_meter: RTL and testbench

//  Measures the frequency of an external, asynchronous square wave (e.g. a divided 1 Hz / kHz clock)
//  by counting its rising edges over a fixed gate window of clk_in cycles. It is the measuring end of
//  the divider chain: dividers generate slow clocks, and this block reads one back for the 7-seg display / self-test.

---
 rtl/freq_meter_pkg.sv | 14 +
 rtl/sync_edge_det.sv | 35 +++
 rtl/freq_meter.sv | 177 +++++++++++++++++
 tb/tb_freq_meter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared types and constants for the frequency meter slice.
package freq_meter_pkg;

  // Measurement sequencer states: wait for enable, count inside the gate, publish.
  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LATCH
  } fm_state_t;

  // Number of completed windows folded into the averaged result.
  localparam int AVG_DEPTH = 4;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: brings an asynchronous level into the local clock domain
// through a STAGES-deep flop chain and emits a registered one-cycle pulse on
// each rising edge of the synchronized level. Reusable for push-buttons.
module sync_edge_det
  import freq_meter_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;

  // Synchronizer chain plus previous-sample and rising-edge registers; the
  // previous sample starts at 0 so a level already high after reset counts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], sig_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous square wave over a gate
// window of GATE_CYCLES clk_in cycles and publishes the count once per window
// with a one-cycle freq_valid strobe.
// Build option: define FREQ_METER_AVG_EN to report the truncated mean of the
// last four window counts; freq_valid then stays quiet until four windows
// have completed since reset.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int                GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  fm_state_t         state_q;
  logic [GATE_W-1:0] gate_cnt_q;
  logic [CNT_W-1:0]  edge_cnt_q;
  logic [CNT_W-1:0]  edge_cnt_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              rise;
  logic              latch_evt;
  logic [CNT_W-1:0]  result_d;
  logic              result_ovf_d;
  logic              result_vld_d;
  logic [CNT_W-1:0]  freq_out_q;
  logic              overflow_q;
  logic              valid_q;
  logic              busy_q;

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_in),
    .rst_ni (reset_n),
    .sig_i  (sig_in),
    .rise_o (rise)
  );

  // Next edge count: saturate at all-ones and flag any edge that could not be counted.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    if (rise) begin
      if (&edge_cnt_q) begin
        ovf_d = 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + CNT_W'(1);
      end
    end
  end

  // The last gate cycle: its edge is still counted and the result is published on this edge.
  assign latch_evt = (state_q == MEASURE) && (gate_cnt_q == GATE_LAST);

`ifdef FREQ_METER_AVG_EN
  logic [CNT_W-1:0]       hist_q [AVG_DEPTH];
  logic [AVG_DEPTH-2:0]   hist_ovf_q;
  logic [CNT_W+1:0]       sum_q;
  logic [CNT_W+1:0]       sum_d;
  logic [2:0]             fill_q;

  // Running sum replaces the oldest count with the window just closing; the
  // result is valid only once the history holds four real windows.
  always_comb begin
    sum_d        = sum_q + {2'b00, edge_cnt_d} - {2'b00, hist_q[AVG_DEPTH-1]};
    result_d     = sum_d[CNT_W+1:2];
    result_ovf_d = ovf_d | (|hist_ovf_q);
    result_vld_d = (fill_q >= 3'(AVG_DEPTH - 1));
  end

  // History of window counts and overflow flags; kept across enable drops, cleared only by reset.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < AVG_DEPTH; i++) begin
        hist_q[i] <= '0;
      end
      hist_ovf_q <= '0;
      sum_q      <= '0;
      fill_q     <= '0;
    end else if (latch_evt) begin
      hist_q[0] <= edge_cnt_d;
      for (int i = 1; i < AVG_DEPTH; i++) begin
        hist_q[i] <= hist_q[i-1];
      end
      hist_ovf_q <= {hist_ovf_q[AVG_DEPTH-3:0], ovf_d};
      sum_q      <= sum_d;
      if (fill_q < 3'(AVG_DEPTH)) begin
        fill_q <= fill_q + 3'd1;
      end
    end
  end
`else
  // Raw mode: every window publishes its own count and overflow flag.
  always_comb begin
    result_d     = edge_cnt_d;
    result_ovf_d = ovf_d;
    result_vld_d = 1'b1;
  end
`endif

  // Measurement sequencer with registered outputs; results are loaded on the
  // edge that enters LATCH so freq_out, overflow and freq_valid are visible
  // during the LATCH cycle itself.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      freq_out_q <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q    <= MEASURE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        MEASURE: begin
          gate_cnt_q <= gate_cnt_q + GATE_W'(1);
          edge_cnt_q <= edge_cnt_d;
          ovf_q      <= ovf_d;
          if (latch_evt) begin
            state_q <= LATCH;
            busy_q  <= 1'b0;
            if (result_vld_d) begin
              freq_out_q <= result_d;
              overflow_q <= result_ovf_d;
              valid_q    <= 1'b1;
            end
          end
        end
        LATCH: begin
          gate_cnt_q <= '0;
          edge_cnt_q <= '0;
          ovf_q      <= 1'b0;
          if (enable) begin
            state_q <= MEASURE;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign freq_out   = freq_out_q;
  assign freq_valid = valid_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: two meters (8-bit and 5-bit counters) share one stimulus.
// A window-level reference model predicts every published result cycle by cycle.
module tb_freq_meter;

  localparam int GATE = 100;
  localparam int WIN  = GATE + 1;
  localparam int MAXC = 32768;
  localparam int AVGN = 4;
`ifdef FREQ_METER_AVG_EN
  localparam int SETTLE = 6;
`else
  localparam int SETTLE = 2;
`endif

  logic       clk_in  = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b0;
  logic       sig_in  = 1'b0;
  logic [7:0] fo8;
  logic       fv8, ov8, bz8;
  logic [4:0] fo5;
  logic       fv5, ov5, bz5;

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(8), .SYNC_STAGES(2)) dut8 (
    .clk_in(clk_in), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
    .freq_out(fo8), .freq_valid(fv8), .overflow(ov8), .busy(bz8)
  );

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(5), .SYNC_STAGES(2)) dut5 (
    .clk_in(clk_in), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
    .freq_out(fo5), .freq_valid(fv5), .overflow(ov5), .busy(bz5)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Signal generator: 0 = manual level, 1 = square wave of sigPeriod clocks, 2 = random bits.
  int   sigMode   = 0;
  int   sigPeriod = 10;
  logic manualSig = 1'b0;
  int   phase     = 0;

  // Reference model state: per-clock samples, current window, expected outputs.
  bit sampArr [MAXC];
  bit enArr   [MAXC];
  bit rstArr  [MAXC];
  int cyc        = 0;
  int winStart   = -1;
  bit pending    = 1'b0;
  int expFo [2]  = '{0, 0};
  int expOv [2]  = '{0, 0};
  int maxv  [2]  = '{255, 31};
  int expValid   = 0;
  int expBusy    = 0;
  int validSeen  = 0;
`ifdef FREQ_METER_AVG_EN
  int histRaw [2][AVGN];
  int histOv  [2][AVGN];
  int latches = 0;
`endif

  typedef struct {
    int period;
    int nominal;
    int ovf5;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    checks++;
    if (actual !== 32'(expected)) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkNear(input string name, input logic [31:0] actual, input int nominal);
    int a;
    a = int'(actual);
    checks++;
    if ($isunknown(actual) || a < nominal - 1 || a > nominal + 1) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d +/-1 at %0t", name, actual, nominal, $time);
    end
  endtask

  task automatic applyStimulus(input int period, input logic en);
    sigMode   = 1;
    sigPeriod = period;
    @(posedge clk_in);
    #3 enable = en;
  endtask

  task automatic pulseReset();
    @(posedge clk_in);
    #3 reset_n = 1'b0;
    repeat (3) @(posedge clk_in);
    #3 reset_n = 1'b1;
  endtask

  // A synchronized rise reaches the counter three clocks after sig_in is first sampled high.
  function automatic int riseAt(input int t);
    int s3, s4;
    s3 = (t >= 3) ? int'(sampArr[t-3]) : 0;
    s4 = (t >= 4) ? int'(sampArr[t-4]) : 0;
    return (s3 == 1 && s4 == 0) ? 1 : 0;
  endfunction

  task automatic latchWindow(input int s, input int e);
    int raw, sat, ov;
    raw = 0;
    for (int t = s; t <= e; t++) raw += riseAt(t);
`ifdef FREQ_METER_AVG_EN
    latches++;
`endif
    for (int k = 0; k < 2; k++) begin
      sat = (raw > maxv[k]) ? maxv[k] : raw;
      ov  = (raw > maxv[k]) ? 1 : 0;
`ifdef FREQ_METER_AVG_EN
      for (int j = AVGN - 1; j > 0; j--) begin
        histRaw[k][j] = histRaw[k][j-1];
        histOv[k][j]  = histOv[k][j-1];
      end
      histRaw[k][0] = sat;
      histOv[k][0]  = ov;
      if (latches >= AVGN) begin
        expFo[k] = (histRaw[k][0] + histRaw[k][1] + histRaw[k][2] + histRaw[k][3]) / 4;
        expOv[k] = (histOv[k][0] | histOv[k][1] | histOv[k][2] | histOv[k][3]);
        expValid = 1;
      end
`else
      expFo[k] = sat;
      expOv[k] = ov;
      expValid = 1;
`endif
    end
  endtask

  task automatic modelStep(input int c);
    expValid = 0;
    if (!reset_n || rstArr[c]) begin
      winStart = -1;
      pending  = 1'b0;
      expFo    = '{0, 0};
      expOv    = '{0, 0};
`ifdef FREQ_METER_AVG_EN
      latches = 0;
      for (int k = 0; k < 2; k++)
        for (int j = 0; j < AVGN; j++) begin
          histRaw[k][j] = 0;
          histOv[k][j]  = 0;
        end
`endif
    end else if (pending) begin
      pending = 1'b0;
      if (enArr[c]) winStart = c + 1;
    end else if (winStart >= 0) begin
      if (c == winStart + GATE - 1) begin
        latchWindow(winStart, c);
        winStart = -1;
        pending  = 1'b1;
      end
    end else if (enArr[c]) begin
      winStart = c + 1;
    end
    expBusy = (winStart >= 0) ? 1 : 0;
  endtask

  // Drives sig_in on falling edges from the selected source.
  initial begin
    forever begin
      @(negedge clk_in);
      case (sigMode)
        1: begin
          phase  = (phase + 1) % sigPeriod;
          sig_in = (phase < sigPeriod / 2);
        end
        2:       sig_in = 1'($urandom_range(0, 1));
        default: sig_in = manualSig;
      endcase
    end
  end

  // Records inputs at each rising edge, then checks all outputs against the model at the falling edge.
  initial begin
    int c;
    forever begin
      @(posedge clk_in);
      c = cyc;
      if (c < MAXC) begin
        sampArr[c] = reset_n & sig_in;
        enArr[c]   = reset_n & enable;
        rstArr[c]  = ~reset_n;
      end
      cyc = cyc + 1;
      @(negedge clk_in);
      if (c < MAXC) begin
        modelStep(c);
        checkOutput("fo8", 32'(fo8), expFo[0]);
        checkOutput("ov8", 32'(ov8), expOv[0]);
        checkOutput("fv8", 32'(fv8), expValid);
        checkOutput("bz8", 32'(bz8), expBusy);
        checkOutput("fo5", 32'(fo5), expFo[1]);
        checkOutput("ov5", 32'(ov5), expOv[1]);
        checkOutput("fv5", 32'(fv5), expValid);
        checkOutput("bz5", 32'(bz5), expBusy);
      end
      if (fv8 === 1'b1) validSeen++;
    end
  end

  // Directed sequences, vector table and randomized phase.
  initial begin
    vec_t tbl [8];
    int   base;
    int   burst [4];

    tbl[0] = '{10, 10, 0};
    tbl[1] = '{20,  5, 0};
    tbl[2] = '{ 4, 25, 0};
    tbl[3] = '{ 2, 50, 1};
    tbl[4] = '{10, 10, 0};
    tbl[5] = '{ 3, 33, 1};
    tbl[6] = '{ 7, 14, 0};
    tbl[7] = '{25,  4, 0};

    repeat (3) @(posedge clk_in);
    #3 reset_n = 1'b1;

    $display("[TB] idle with toggling input");
    applyStimulus(6, 1'b0);
    repeat (250) @(posedge clk_in);
    #3;
    checkOutput("idle_busy", 32'(bz8), 0);
    checkOutput("idle_valid_count", 32'(validSeen), 0);
    checkOutput("idle_freq", 32'(fo8), 0);

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].period, 1'b1);
      repeat (SETTLE * WIN + 10) @(posedge clk_in);
      #3;
      checkNear($sformatf("tbl%0d_fo8", i), 32'(fo8), tbl[i].nominal);
      checkOutput($sformatf("tbl%0d_ov8", i), 32'(ov8), 0);
      checkOutput($sformatf("tbl%0d_ov5", i), 32'(ov5), tbl[i].ovf5);
      if (tbl[i].ovf5 != 0)
        checkOutput($sformatf("tbl%0d_fo5", i), 32'(fo5), 31);
      else
        checkNear($sformatf("tbl%0d_fo5", i), 32'(fo5), tbl[i].nominal);
    end

    $display("[TB] enable dropped mid-window");
    #3 enable = 1'b0;
    repeat (2 * WIN + 5) @(posedge clk_in);
    base = validSeen;
    #3 enable = 1'b1;
    repeat (31) @(posedge clk_in);
    #3 enable = 1'b0;
    repeat (WIN + 40) @(posedge clk_in);
    #3;
    checkOutput("drop_valid_count", 32'(validSeen - base), 1);
    checkOutput("drop_busy", 32'(bz8), 0);

    $display("[TB] reset mid-window");
    applyStimulus(10, 1'b1);
    repeat (SETTLE * WIN + 10) @(posedge clk_in);
    #3 checkNear("pre_reset_fo8", 32'(fo8), 10);
    repeat (40) @(posedge clk_in);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("rst_fo8", 32'(fo8), 0);
    checkOutput("rst_fo5", 32'(fo5), 0);
    checkOutput("rst_busy", 32'(bz8), 0);
    checkOutput("rst_valid", 32'(fv8), 0);
    repeat (3) @(posedge clk_in);
    #3 reset_n = 1'b1;
    repeat (SETTLE * WIN + 10) @(posedge clk_in);
    #3 checkNear("restart_fo8", 32'(fo8), 10);

    $display("[TB] randomized stimulus");
    for (int i = 0; i < 24; i++) begin
      sigMode   = ($urandom_range(0, 2) == 0) ? 1 : 2;
      sigPeriod = $urandom_range(2, 30);
      @(posedge clk_in);
      #3 enable = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) pulseReset();
      repeat ($urandom_range(20, 260)) @(posedge clk_in);
    end
    sigMode = 2;
    @(posedge clk_in);
    #3 enable = 1'b1;
    repeat (5 * WIN) @(posedge clk_in);
    #3 enable = 1'b0;
    repeat (2 * WIN) @(posedge clk_in);

`ifdef FREQ_METER_AVG_EN
    $display("[TB] averaging over bursts 8,12,10,14");
    burst = '{8, 12, 10, 14};
    sigMode   = 0;
    manualSig = 1'b0;
    pulseReset();
    repeat (5) @(posedge clk_in);
    base = validSeen;
    #3 enable = 1'b1;
    for (int w = 0; w < 4; w++) begin
      repeat (10) @(posedge clk_in);
      for (int p = 0; p < burst[w]; p++) begin
        manualSig = 1'b1;
        repeat (2) @(posedge clk_in);
        manualSig = 1'b0;
        repeat (2) @(posedge clk_in);
      end
      repeat (WIN - 10 - 4 * burst[w]) @(posedge clk_in);
    end
    #3;
    enable = 1'b0;
    checkOutput("avg_fo8", 32'(fo8), 11);
    checkOutput("avg_fo5", 32'(fo5), 11);
    checkOutput("avg_valid_count", 32'(validSeen - base), 1);
    checkOutput("avg_ov8", 32'(ov8), 0);
    repeat (2 * WIN) @(posedge clk_in);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
